// File: rtl/sr_flag_arbiter.sv
// Bank of SR status flags updated through one round-robin arbitrated port.
// Supports lock for back-to-back ownership and a global synchronous clear.
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDX_W = (NFLAG > 1) ? $clog2(NFLAG) : 1,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       cmd_s,
    input  logic [NREQ-1:0]       cmd_r,
    input  logic [NREQ*IDX_W-1:0] idx,
    input  logic [NREQ-1:0]       lock,
    input  logic                  clr_all,
    output logic [NREQ-1:0]       gnt,
    output logic [NFLAG-1:0]      q,
    output logic                  upd_valid,
    output logic [ID_W-1:0]       upd_id,
    output logic                  idx_err
);

    typedef enum logic {IDLE, LOCKED} mode_e;

    mode_e             mode_q, mode_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [NFLAG-1:0]  q_q, q_d;
    logic              upd_valid_q, upd_valid_d;
    logic [ID_W-1:0]   upd_id_q, upd_id_d;
    logic              idx_err_q, idx_err_d;

    logic              xfer;
    logic [ID_W-1:0]   gid;
    logic [IDX_W-1:0]  gidx;
    int                cand;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        if (int'(v) == NREQ - 1) return '0;
        return v + 1'b1;
    endfunction

    // Reset dominates: 11 clears the flag.
    function automatic logic sr_next(input logic cur, input logic s, input logic r);
        if (r) return 1'b0;
        if (s) return 1'b1;
        return cur;
    endfunction

    always_comb begin
        gnt  = '0;
        xfer = 1'b0;
        gid  = '0;
        cand = 0;
        if (rst_n && !clr_all) begin
            if (mode_q == LOCKED) begin
                gnt[owner_q] = req[owner_q];
                xfer         = req[owner_q];
                gid          = owner_q;
            end else begin
                // Descending scan so the candidate closest to ptr wins.
                for (int k = NREQ - 1; k >= 0; k--) begin
                    cand = (int'(ptr_q) + k) % NREQ;
                    if (req[cand]) begin
                        xfer = 1'b1;
                        gid  = ID_W'(cand);
                    end
                end
                if (xfer) gnt[gid] = 1'b1;
            end
        end
    end

    assign gidx = idx[gid*IDX_W +: IDX_W];

    always_comb begin
        mode_d      = mode_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        q_d         = q_q;
        upd_valid_d = 1'b0;
        upd_id_d    = upd_id_q;
        idx_err_d   = 1'b0;
        if (clr_all) begin
            q_d = '0;
        end else if (xfer) begin
            upd_valid_d = 1'b1;
            upd_id_d    = gid;
            ptr_d       = wrap_inc(gid);
            if (32'(gidx) < NFLAG) q_d[gidx] = sr_next(q_q[gidx], cmd_s[gid], cmd_r[gid]);
            else                   idx_err_d = 1'b1;
            if (lock[gid]) begin
                mode_d  = LOCKED;
                owner_d = gid;
            end else begin
                mode_d  = IDLE;
            end
        end else if (mode_q == LOCKED && !req[owner_q]) begin
            mode_d = IDLE;
            ptr_d  = wrap_inc(owner_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q      <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            q_q         <= '0;
            upd_valid_q <= 1'b0;
            upd_id_q    <= '0;
            idx_err_q   <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            q_q         <= q_d;
            upd_valid_q <= upd_valid_d;
            upd_id_q    <= upd_id_d;
            idx_err_q   <= idx_err_d;
        end
    end

    assign q         = q_q;
    assign upd_valid = upd_valid_q;
    assign upd_id    = upd_id_q;
    assign idx_err   = idx_err_q;

endmodule
